// File: rtl/run_length_detector_pkg.sv
// run_det_pkg: shared mode encodings and FSM state type for the run-length detector
package run_det_pkg;
  localparam logic [1:0] MODE_LEVEL  = 2'd0;
  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_NONOVL = 2'd2;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    HIT    = 2'd2
  } state_t;
endpackage

// File: rtl/run_length_detector_sat_counter.sv
// sat_counter: counter with sync active-low reset, clear, zero-load and a saturating increment
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         zero,
  input  logic         inc,
  output logic [W-1:0] q
);
  // clearing wins over increment; the count sticks at all-ones
  always_ff @(posedge clk)
    if (!rst || clr || zero) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/run_length_detector.sv
// run_length_detector: flags runs of THRESH consecutive ones in level, single-pulse or non-overlapping mode
module run_length_detector
  import run_det_pkg::*;
#(
  parameter int THRESH = 3,
  parameter int CNT_W  = 4,
  parameter int EVT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             a,
  output logic             y,
  output logic             armed,
  output logic [CNT_W-1:0] run_len,
  output logic [EVT_W-1:0] hit_cnt
);
  localparam logic [CNT_W-1:0] TH1 = CNT_W'(THRESH - 1);
  if (THRESH < 1) begin : g_bad_thresh
    $fatal(1, "THRESH must be at least 1");
  end
  if ((2 ** CNT_W) - 1 < THRESH) begin : g_bad_cnt_w
    $fatal(1, "CNT_W too narrow to hold THRESH");
  end
  if (EVT_W < 1) begin : g_bad_evt_w
    $fatal(1, "EVT_W must be at least 1");
  end
  state_t           state, state_nxt;
  logic             run_zero, run_inc;
  logic [CNT_W-1:0] len_nxt;
  // run length update: a zero (or a non-overlapping hit) restarts the count
  always_comb begin
    run_zero = en && (!a || (mode == MODE_NONOVL && y));
    run_inc  = en && a;
    len_nxt  = !en ? run_len : run_zero ? '0 : (&run_len) ? run_len : run_len + 1'b1;
  end
  // FSM state register, cleared by reset or clr
  always_ff @(posedge clk)
    if (!rst || clr) state <= IDLE;
    else state <= state_nxt;
  // next state follows the run length the counter is about to take
  always_comb
    state_nxt = !en ? state : (len_nxt == '0) ? IDLE : (len_nxt >= TH1) ? HIT : ARMING;
  // Mealy hit flag on the completing bit; reserved mode decodes as level
  always_comb begin
    y     = rst && !clr && en && a &&
            ((mode == MODE_PULSE || mode == MODE_NONOVL) ? run_len == TH1 : run_len >= TH1);
    armed = state == HIT;
  end
  sat_counter #(.W(CNT_W)) u_run (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .zero(run_zero),
    .inc (run_inc),
    .q   (run_len)
  );
  sat_counter #(.W(EVT_W)) u_hit (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .zero(1'b0),
    .inc (y),
    .q   (hit_cnt)
  );
endmodule
